// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters and the SDRAM
// controller command port. The arbiter uses the slave view; the
// surrounding environment drives through the master view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    // VGA line fetcher side
    logic              vga_req;
    logic              vga_urgent;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_done;
    // Host bridge side
    logic              host_req;
    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    // SDRAM controller command port
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_wr;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_cmd_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    // Status
    logic              busy;

    modport slave (
        input  vga_req, vga_urgent, vga_addr,
        input  host_req, host_wr, host_addr, host_wdata,
        input  mem_cmd_ready, mem_rvalid, mem_rdata,
        output vga_gnt, vga_rvalid, vga_rdata, vga_done,
        output host_ack, host_rdata,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        output busy
    );

    modport master (
        output vga_req, vga_urgent, vga_addr,
        output host_req, host_wr, host_addr, host_wdata,
        output mem_cmd_ready, mem_rvalid, mem_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata, vga_done,
        input  host_ack, host_rdata,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        input  busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between the VGA line fetcher
// (BURST_LEN-word read bursts) and the host bridge (single-word accesses).
// An urgent VGA request always wins; otherwise simultaneous requests
// alternate so that neither side starves. All outputs are registered.
module sdram_port_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    sdram_port_arbiter_if.slave arb
);
    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VGA_CMD   = 3'd1,
        ST_VGA_WAIT  = 3'd2,
        ST_HOST_CMD  = 3'd3,
        ST_HOST_WAIT = 3'd4
    } state_t;

    state_t            state_r;
    logic              last_host_r;
    logic [7:0]        cmd_cnt_r;
    logic [7:0]        ret_cnt_r;
    logic              vga_gnt_r;
    logic              vga_rvalid_r;
    logic [DATA_W-1:0] vga_rdata_r;
    logic              vga_done_r;
    logic              host_ack_r;
    logic [DATA_W-1:0] host_rdata_r;
    logic              mem_cmd_valid_r;
    logic              mem_cmd_wr_r;
    logic [ADDR_W-1:0] mem_cmd_addr_r;
    logic [DATA_W-1:0] mem_cmd_wdata_r;
    logic              busy_r;

    logic              cmd_fire_s;
    logic              vga_pick_s;
    logic              vga_ret_s;

    // Command handshake, arbitration winner and VGA read-return qualification.
    always_comb begin
        cmd_fire_s = mem_cmd_valid_r && arb.mem_cmd_ready;
        // VGA wins when urgent, when alone, or when the host was served last.
        vga_pick_s = arb.vga_req && (arb.vga_urgent || !arb.host_req || last_host_r);
        // Returns outside a VGA burst are stale (e.g. left over from a reset) and dropped.
        vga_ret_s  = arb.mem_rvalid && ((state_r == ST_VGA_CMD) || (state_r == ST_VGA_WAIT));
    end

    // Arbitration FSM with all outputs registered; pulse outputs default low every cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r         <= ST_IDLE;
            last_host_r     <= 1'b1;
            cmd_cnt_r       <= 8'd0;
            ret_cnt_r       <= 8'd0;
            vga_gnt_r       <= 1'b0;
            vga_rvalid_r    <= 1'b0;
            vga_rdata_r     <= {DATA_W{1'b0}};
            vga_done_r      <= 1'b0;
            host_ack_r      <= 1'b0;
            host_rdata_r    <= {DATA_W{1'b0}};
            mem_cmd_valid_r <= 1'b0;
            mem_cmd_wr_r    <= 1'b0;
            mem_cmd_addr_r  <= {ADDR_W{1'b0}};
            mem_cmd_wdata_r <= {DATA_W{1'b0}};
            busy_r          <= 1'b0;
        end else begin
            vga_gnt_r    <= 1'b0;
            vga_rvalid_r <= 1'b0;
            vga_done_r   <= 1'b0;
            host_ack_r   <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (vga_pick_s) begin
                        state_r         <= ST_VGA_CMD;
                        vga_gnt_r       <= 1'b1;
                        mem_cmd_valid_r <= 1'b1;
                        mem_cmd_wr_r    <= 1'b0;
                        mem_cmd_addr_r  <= arb.vga_addr;
                        cmd_cnt_r       <= 8'd0;
                        ret_cnt_r       <= 8'd0;
                        last_host_r     <= 1'b0;
                        busy_r          <= 1'b1;
                    end else if (arb.host_req) begin
                        state_r         <= ST_HOST_CMD;
                        mem_cmd_valid_r <= 1'b1;
                        mem_cmd_wr_r    <= arb.host_wr;
                        mem_cmd_addr_r  <= arb.host_addr;
                        mem_cmd_wdata_r <= arb.host_wdata;
                        last_host_r     <= 1'b1;
                        busy_r          <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_VGA_CMD: begin
                    if (cmd_fire_s) begin
                        cmd_cnt_r <= cmd_cnt_r + 8'd1;
                        if (cmd_cnt_r == LAST_IDX) begin
                            mem_cmd_valid_r <= 1'b0;
                            state_r         <= ST_VGA_WAIT;
                        end else begin
                            // Burst address wraps naturally at 2^ADDR_W.
                            mem_cmd_addr_r <= mem_cmd_addr_r + ADDR_W'(1);
                        end
                    end else begin
                        state_r <= ST_VGA_CMD;
                    end
                end

                ST_VGA_WAIT: begin
                    state_r <= ST_VGA_WAIT;
                end

                ST_HOST_CMD: begin
                    if (cmd_fire_s) begin
                        mem_cmd_valid_r <= 1'b0;
                        if (mem_cmd_wr_r) begin
                            host_ack_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            state_r <= ST_HOST_WAIT;
                        end
                    end else begin
                        state_r <= ST_HOST_CMD;
                    end
                end

                ST_HOST_WAIT: begin
                    if (arb.mem_rvalid) begin
                        host_rdata_r <= arb.mem_rdata;
                        host_ack_r   <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOST_WAIT;
                    end
                end

                default: begin
                    state_r         <= ST_IDLE;
                    mem_cmd_valid_r <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase

            // Burst read returns are forwarded one cycle later; the last one ends the burst.
            if (vga_ret_s) begin
                vga_rvalid_r <= 1'b1;
                vga_rdata_r  <= arb.mem_rdata;
                ret_cnt_r    <= ret_cnt_r + 8'd1;
                if (ret_cnt_r == LAST_IDX) begin
                    vga_done_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end else begin
                    vga_done_r <= 1'b0;
                end
            end else begin
                vga_rvalid_r <= 1'b0;
            end
        end
    end

    assign arb.vga_gnt       = vga_gnt_r;
    assign arb.vga_rvalid    = vga_rvalid_r;
    assign arb.vga_rdata     = vga_rdata_r;
    assign arb.vga_done      = vga_done_r;
    assign arb.host_ack      = host_ack_r;
    assign arb.host_rdata    = host_rdata_r;
    assign arb.mem_cmd_valid = mem_cmd_valid_r;
    assign arb.mem_cmd_wr    = mem_cmd_wr_r;
    assign arb.mem_cmd_addr  = mem_cmd_addr_r;
    assign arb.mem_cmd_wdata = mem_cmd_wdata_r;
    assign arb.busy          = busy_r;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. A small SDRAM controller model
// (random or always-ready command port, fixed read latency, word memory
// that returns the low address bits for unwritten words) runs on the
// falling edge next to a monitor that logs commands, grants and returns.
module tb_sdram_port_arbiter;
    logic sys_clk;
    logic sys_rst;

    sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(16)) arb();

    sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .BURST_LEN(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .arb     (arb.slave)
    );

    int checks;
    int errors;

    // Controller model and monitor state
    logic              rand_ready;
    logic              stall_chk;
    logic              stall_prev;
    logic [41:0]       stall_snap;
    logic              prev_valid;
    logic [2:0]        pv;
    logic [15:0]       pd [3];
    logic [15:0]       rd_word;
    logic [15:0]       mem_a [logic [23:0]];
    logic [23:0]       cl_addr [$];
    logic              cl_wr [$];
    logic [15:0]       cl_wdata [$];
    logic [15:0]       vq [$];
    logic [15:0]       done_q [$];
    logic              glog [$];
    int                ack_cnt;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({arb.vga_gnt, arb.vga_rvalid, arb.vga_rdata, arb.vga_done,
                     arb.host_ack, arb.host_rdata, arb.mem_cmd_valid, arb.mem_cmd_wr,
                     arb.mem_cmd_addr, arb.mem_cmd_wdata, arb.busy});
    endfunction

    // Controller model and monitor, evaluated away from the active edge.
    always @(negedge sys_clk) begin
        if (stall_chk && stall_prev)
            chk("stall_hold", 128'({arb.mem_cmd_valid, arb.mem_cmd_wr, arb.mem_cmd_addr, arb.mem_cmd_wdata}),
                128'(stall_snap));
        arb.mem_cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        arb.mem_rvalid = pv[0];
        arb.mem_rdata  = pd[0];
        pv    = {1'b0, pv[2:1]};
        pd[0] = pd[1];
        pd[1] = pd[2];
        pd[2] = 16'h0000;
        if (arb.mem_cmd_valid && arb.mem_cmd_ready && !sys_rst) begin
            cl_addr.push_back(arb.mem_cmd_addr);
            cl_wr.push_back(arb.mem_cmd_wr);
            cl_wdata.push_back(arb.mem_cmd_wdata);
            if (arb.mem_cmd_wr) begin
                mem_a[arb.mem_cmd_addr] = arb.mem_cmd_wdata;
            end else begin
                rd_word = mem_a.exists(arb.mem_cmd_addr) ? mem_a[arb.mem_cmd_addr] : arb.mem_cmd_addr[15:0];
                pv[2] = 1'b1;
                pd[2] = rd_word;
            end
        end
        stall_prev = arb.mem_cmd_valid && !arb.mem_cmd_ready;
        stall_snap = {arb.mem_cmd_valid, arb.mem_cmd_wr, arb.mem_cmd_addr, arb.mem_cmd_wdata};
        if (arb.vga_rvalid) vq.push_back(arb.vga_rdata);
        if (arb.vga_done) done_q.push_back(arb.vga_rdata);
        if (arb.mem_cmd_valid && !prev_valid) glog.push_back(!arb.vga_gnt);
        prev_valid = arb.mem_cmd_valid;
        if (arb.host_ack) ack_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_logs();
        cl_addr.delete(); cl_wr.delete(); cl_wdata.delete();
        vq.delete(); done_q.delete(); glog.delete();
    endtask

    task automatic wait_vga_gnt(input string tag);
        int k = 0;
        while (arb.vga_gnt !== 1'b1 && k < 300) begin @(negedge sys_clk); k++; end
        chk(tag, 128'(arb.vga_gnt), 128'(1'b1));
    endtask

    task automatic wait_vga_done(input string tag);
        int k = 0;
        while (arb.vga_done !== 1'b1 && k < 300) begin @(negedge sys_clk); k++; end
        chk(tag, 128'(arb.vga_done), 128'(1'b1));
    endtask

    task automatic wait_host_ack(input string tag);
        int k = 0;
        while (arb.host_ack !== 1'b1 && k < 300) begin @(negedge sys_clk); k++; end
        chk(tag, 128'(arb.host_ack), 128'(1'b1));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (arb.busy !== 1'b0 && k < 300) begin @(negedge sys_clk); k++; end
        chk(tag, 128'(arb.busy), 128'(1'b0));
    endtask

    task automatic run_burst(input logic [23:0] base, input string tag);
        arb.vga_addr = base;
        arb.vga_req  = 1'b1;
        wait_vga_gnt({tag, "_gnt"});
        arb.vga_req  = 1'b0;
        wait_vga_done({tag, "_done"});
    endtask

    task automatic host_op(input logic wr, input logic [23:0] a, input logic [15:0] d, input string tag);
        arb.host_wr    = wr;
        arb.host_addr  = a;
        arb.host_wdata = d;
        arb.host_req   = 1'b1;
        wait_host_ack(tag);
        arb.host_req   = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(2);
    endtask

    task automatic chk_burst(input logic [23:0] base, input string tag);
        logic [23:0] ea;
        chk({tag, "_ncmd"}, 128'(cl_addr.size()), 128'(8));
        chk({tag, "_nret"}, 128'(vq.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            ea = base + 24'(i);
            chk({tag, "_cmd"}, 128'({cl_wr[i], cl_addr[i]}), 128'({1'b0, ea}));
            chk({tag, "_ret"}, 128'(vq[i]), 128'(ea[15:0]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1;
        int a0;
        checks = 0; errors = 0; ack_cnt = 0;
        rand_ready = 1'b0; stall_chk = 1'b0; stall_prev = 1'b0; stall_snap = 42'd0;
        prev_valid = 1'b0; pv = 3'b000; rd_word = 16'h0000;
        for (int i = 0; i < 3; i++) pd[i] = 16'h0000;
        sys_rst = 1'b1;
        arb.vga_req = 1'b0; arb.vga_urgent = 1'b0; arb.vga_addr = 24'h0;
        arb.host_req = 1'b0; arb.host_wr = 1'b0; arb.host_addr = 24'h0; arb.host_wdata = 16'h0;
        arb.mem_cmd_ready = 1'b1; arb.mem_rvalid = 1'b0; arb.mem_rdata = 16'h0;

        // Reset state
        tick(3);
        chk("reset_outputs", all_outs(), 128'd0);
        sys_rst = 1'b0;
        tick(2);
        chk("idle_outputs", all_outs(), 128'd0);

        // 1: lone VGA burst at 0x10, grant one cycle after request
        clear_logs();
        arb.vga_addr = 24'h000010;
        arb.vga_req  = 1'b1;
        tick(1);
        chk("t1_gnt", 128'(arb.vga_gnt), 128'(1'b1));
        chk("t1_first_cmd", 128'({arb.mem_cmd_valid, arb.mem_cmd_wr, arb.mem_cmd_addr, arb.busy}),
            128'({1'b1, 1'b0, 24'h000010, 1'b1}));
        arb.vga_req = 1'b0;
        wait_vga_done("t1_done");
        chk("t1_done_word", 128'({arb.vga_rvalid, arb.vga_rdata, arb.busy}), 128'({1'b1, 16'h0017, 1'b0}));
        tick(2);
        chk_burst(24'h000010, "t1");

        // 2: host write then read back
        clear_logs();
        ack_cnt = 0;
        arb.host_wr = 1'b1; arb.host_addr = 24'h000100; arb.host_wdata = 16'hBEEF; arb.host_req = 1'b1;
        tick(2);
        chk("t2_wr_ack", 128'(arb.host_ack), 128'(1'b1));
        arb.host_req = 1'b0;
        tick(2);
        host_op(1'b0, 24'h000100, 16'h0000, "t2_rd_ack");
        chk("t2_rdata", 128'(arb.host_rdata), 128'(16'hBEEF));
        tick(3);
        chk("t2_rdata_hold", 128'(arb.host_rdata), 128'(16'hBEEF));
        chk("t2_cmds", 128'({cl_wr[0], cl_addr[0], cl_wdata[0], cl_wr[1], cl_addr[1]}),
            128'({1'b1, 24'h000100, 16'hBEEF, 1'b0, 24'h000100}));
        chk("t2_ack_count", 128'(ack_cnt), 128'(2));

        // 3: both requesters held from reset alternate VGA, HOST, VGA, HOST
        do_reset();
        clear_logs();
        arb.vga_addr = 24'h000200;
        arb.host_wr = 1'b1; arb.host_addr = 24'h000300; arb.host_wdata = 16'h1234;
        arb.vga_req = 1'b1; arb.host_req = 1'b1;
        a0 = 0;
        while (glog.size() < 4 && a0 < 400) begin tick(1); a0++; end
        arb.vga_req = 1'b0; arb.host_req = 1'b0;
        wait_idle("t3_idle");
        tick(2);
        chk("t3_ngrants", 128'(glog.size()), 128'(4));
        chk("t3_order", 128'({glog[0], glog[1], glog[2], glog[3]}), 128'(4'b0101));

        // 4: VGA served last, so host owns the turn, but urgent VGA still wins
        run_burst(24'h000400, "t4_pre");
        tick(2);
        glog.delete();
        arb.host_wr = 1'b0; arb.host_addr = 24'h000100;
        arb.vga_addr = 24'h000410;
        arb.vga_req = 1'b1; arb.vga_urgent = 1'b1; arb.host_req = 1'b1;
        tick(1);
        chk("t4_urgent_first", 128'(arb.vga_gnt), 128'(1'b1));
        arb.vga_req = 1'b0; arb.vga_urgent = 1'b0;
        wait_vga_done("t4_done");
        wait_host_ack("t4_host_next");
        arb.host_req = 1'b0;
        chk("t4_host_rdata", 128'(arb.host_rdata), 128'(16'hBEEF));
        tick(2);
        chk("t4_order", 128'({glog.size() == 2, glog[0], glog[1]}), 128'(3'b101));

        // 5: burst wrapping past the top of the address space
        clear_logs();
        run_burst(24'hFFFFFE, "t5");
        chk("t5_done_word", 128'(arb.vga_rdata), 128'(16'h0005));
        tick(2);
        chk_burst(24'hFFFFFE, "t5");

        // 6: random command-port backpressure
        rand_ready = 1'b1;
        stall_chk  = 1'b1;
        clear_logs();
        run_burst(24'h000500, "t6");
        tick(2);
        chk_burst(24'h000500, "t6");
        host_op(1'b1, 24'h000104, 16'h5A5A, "t6_wr_ack");
        tick(1);
        host_op(1'b0, 24'h000104, 16'h0000, "t6_rd_ack");
        chk("t6_rdata", 128'(arb.host_rdata), 128'(16'h5A5A));
        tick(2);
        chk("t6_ncmd", 128'(cl_addr.size()), 128'(10));
        stall_chk  = 1'b0;
        rand_ready = 1'b0;
        tick(2);

        // 7: reset in the middle of a burst
        clear_logs();
        arb.vga_addr = 24'h000600;
        arb.vga_req  = 1'b1;
        wait_vga_gnt("t7_gnt");
        arb.vga_req = 1'b0;
        a0 = 0;
        while (vq.size() < 3 && a0 < 100) begin tick(1); a0++; end
        chk("t7_mid_burst", 128'(arb.busy), 128'(1'b1));
        sys_rst = 1'b1;
        tick(1);
        chk("t7_reset_outputs", all_outs(), 128'd0);
        sys_rst = 1'b0;
        n1 = vq.size();
        tick(6);
        chk("t7_stray_dropped", 128'({vq.size() == n1, done_q.size() == 0, arb.busy}), 128'(3'b110));
        ack_cnt = 0;
        host_op(1'b0, 24'h000100, 16'h0000, "t7_rd_ack");
        chk("t7_rdata", 128'(arb.host_rdata), 128'(16'hBEEF));
        tick(3);
        chk("t7_ack_count", 128'(ack_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
